pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the hold and flush controls of the PC and of pipeline registers 1–4 (IF/ID, ID/EX, EX/MEM, MEM/WB) from three sources: memory busywait, load-use hazards and taken branches. It also runs a post-reset drain sequence, a stall watchdog and a saturating stall-cycle counter. It sits beside the datapath, between the hazard sources (memories, ID/EX decode fields, branch unit) and every stage register.

---
 rtl/pipeline_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives PC and stage-register
// hold/flush from busywait, load-use and taken-branch sources, plus drain, watchdog and stall counter.
module pipeline_hazard_ctrl #(
    parameter int INIT_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IMEM_BUSYWAIT,
    input  logic             DMEM_BUSYWAIT,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic [4:0]       EX_RD,
    input  logic             EX_MEMREAD,
    input  logic             EX_BRANCH_TAKEN,
    output logic             PC_HOLD,
    output logic             PC_REDIRECT,
    output logic             PR1_HOLD,
    output logic             PR2_HOLD,
    output logic             PR3_HOLD,
    output logic             PR4_HOLD,
    output logic             PR1_FLUSH,
    output logic             PR2_FLUSH,
    output logic [CNT_W-1:0] STALL_COUNT,
    output logic             STALL_TIMEOUT,
    output logic [1:0]       STATE
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES - 1);
    localparam logic [INIT_W-1:0] INIT_ZERO = '0;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_MEM_STALL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              timeout_q, timeout_d;

    logic busy;
    logic load_use;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= INIT_LOAD;
            wait_cnt_q  <= WAIT_ZERO;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        busy     = IMEM_BUSYWAIT | DMEM_BUSYWAIT;
        load_use = EX_MEMREAD && (EX_RD != 5'd0) &&
                   ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                    (ID_USES_RS2 && (ID_RS2 == EX_RD)));

        PC_HOLD     = 1'b0;
        PC_REDIRECT = 1'b0;
        PR1_HOLD    = 1'b0;
        PR2_HOLD    = 1'b0;
        PR3_HOLD    = 1'b0;
        PR4_HOLD    = 1'b0;
        PR1_FLUSH   = 1'b0;
        PR2_FLUSH   = 1'b0;

        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            ST_INIT: begin
                PC_HOLD    = 1'b1;
                PR1_FLUSH  = 1'b1;
                PR2_FLUSH  = 1'b1;
                wait_cnt_d = WAIT_ZERO;
                if (init_cnt_q != INIT_ZERO) begin
                    init_cnt_d = init_cnt_q - 1'b1;
                end else if (!busy) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_MEM_STALL: begin
                if (busy) begin
                    PC_HOLD  = 1'b1;
                    PR1_HOLD = 1'b1;
                    PR2_HOLD = 1'b1;
                    PR3_HOLD = 1'b1;
                    PR4_HOLD = 1'b1;
                end else if (EX_BRANCH_TAKEN) begin
                    // ID holds a wrong-path instruction, so the branch wins over load-use
                    PC_REDIRECT = 1'b1;
                    PR1_FLUSH   = 1'b1;
                    PR2_FLUSH   = 1'b1;
                end else if (load_use) begin
                    PC_HOLD   = 1'b1;
                    PR1_HOLD  = 1'b1;
                    PR2_FLUSH = 1'b1;
                end

                if (busy) begin
                    state_d = ST_MEM_STALL;
                    if (state_q == ST_RUN) begin
                        wait_cnt_d = WAIT_ONE;
                    end else if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = WAIT_ZERO;
                end

                if (PC_HOLD && (stall_cnt_q != CNT_MAX)) begin
                    stall_cnt_d = stall_cnt_q + CNT_ONE;
                end
            end
            default: begin
                PC_HOLD    = 1'b1;
                PR1_FLUSH  = 1'b1;
                PR2_FLUSH  = 1'b1;
                state_d    = ST_INIT;
                init_cnt_d = INIT_LOAD;
                wait_cnt_d = WAIT_ZERO;
            end
        endcase

        timeout_d = timeout_q | (wait_cnt_d == WAIT_MAX);
    end

    assign STALL_COUNT   = stall_cnt_q;
    assign STALL_TIMEOUT = timeout_q;
    assign STATE         = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with INIT_CYCLES=2, TIMEOUT_CYCLES=4, CNT_W=3.
module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       IMEM_BUSYWAIT = 1'b0;
    logic       DMEM_BUSYWAIT = 1'b0;
    logic [4:0] ID_RS1 = '0;
    logic [4:0] ID_RS2 = '0;
    logic       ID_USES_RS1 = 1'b0;
    logic       ID_USES_RS2 = 1'b0;
    logic [4:0] EX_RD = '0;
    logic       EX_MEMREAD = 1'b0;
    logic       EX_BRANCH_TAKEN = 1'b0;
    logic       PC_HOLD, PC_REDIRECT;
    logic       PR1_HOLD, PR2_HOLD, PR3_HOLD, PR4_HOLD;
    logic       PR1_FLUSH, PR2_FLUSH;
    logic [2:0] STALL_COUNT;
    logic       STALL_TIMEOUT;
    logic [1:0] STATE;

    int tests = 0;
    int fails = 0;

    pipeline_hazard_ctrl #(
        .INIT_CYCLES   (2),
        .TIMEOUT_CYCLES(4),
        .CNT_W         (3)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .IMEM_BUSYWAIT  (IMEM_BUSYWAIT),
        .DMEM_BUSYWAIT  (DMEM_BUSYWAIT),
        .ID_RS1         (ID_RS1),
        .ID_RS2         (ID_RS2),
        .ID_USES_RS1    (ID_USES_RS1),
        .ID_USES_RS2    (ID_USES_RS2),
        .EX_RD          (EX_RD),
        .EX_MEMREAD     (EX_MEMREAD),
        .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
        .PC_HOLD        (PC_HOLD),
        .PC_REDIRECT    (PC_REDIRECT),
        .PR1_HOLD       (PR1_HOLD),
        .PR2_HOLD       (PR2_HOLD),
        .PR3_HOLD       (PR3_HOLD),
        .PR4_HOLD       (PR4_HOLD),
        .PR1_FLUSH      (PR1_FLUSH),
        .PR2_FLUSH      (PR2_FLUSH),
        .STALL_COUNT    (STALL_COUNT),
        .STALL_TIMEOUT  (STALL_TIMEOUT),
        .STATE          (STATE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // packed control vector: {PC_HOLD, PC_REDIRECT, PR1..PR4_HOLD, PR1_FLUSH, PR2_FLUSH}
    function automatic logic [31:0] ctrl();
        return {24'd0, PC_HOLD, PC_REDIRECT, PR1_HOLD, PR2_HOLD, PR3_HOLD, PR4_HOLD,
                PR1_FLUSH, PR2_FLUSH};
    endfunction

    localparam logic [31:0] C_INIT  = 32'b1000_0011;
    localparam logic [31:0] C_NONE  = 32'b0000_0000;
    localparam logic [31:0] C_BUSY  = 32'b1011_1100;
    localparam logic [31:0] C_BR    = 32'b0100_0011;
    localparam logic [31:0] C_LU    = 32'b1010_0001;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        IMEM_BUSYWAIT = 0; DMEM_BUSYWAIT = 0;
        ID_RS1 = 0; ID_RS2 = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
        EX_RD = 0; EX_MEMREAD = 0; EX_BRANCH_TAKEN = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        RESET = 1;
        #1;
        RESET = 0;
        tick();
        chk({tag, "_init_hold"}, STATE, 0);
        tick();
        chk({tag, "_run"}, STATE, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // asynchronous reset, before any clock edge
        #2 RESET = 1;
        #1;
        chk("rst_state", STATE, 0);
        chk("rst_ctrl", ctrl(), C_INIT);
        chk("rst_cnt", STALL_COUNT, 0);
        chk("rst_to", STALL_TIMEOUT, 0);
        #4 RESET = 0;
        tick();
        chk("init_edge1_state", STATE, 0);
        chk("init_edge1_ctrl", ctrl(), C_INIT);
        tick();
        chk("init_edge2_state", STATE, 1);
        chk("run_ctrl_idle", ctrl(), C_NONE);
        chk("run_cnt0", STALL_COUNT, 0);

        // load-use on rs2
        EX_MEMREAD = 1; EX_RD = 5; ID_RS2 = 5; ID_USES_RS2 = 1;
        #1 chk("lu_ctrl", ctrl(), C_LU);
        tick();
        chk("lu_cnt", STALL_COUNT, 1);
        EX_MEMREAD = 0;
        #1 chk("lu_cleared", ctrl(), C_NONE);
        tick();
        chk("lu_one_stall", STALL_COUNT, 1);

        // x0 destination and unused-source match must not stall
        EX_MEMREAD = 1; EX_RD = 0; ID_RS1 = 0; ID_USES_RS1 = 1; ID_RS2 = 0;
        #1 chk("lu_x0", ctrl(), C_NONE);
        EX_RD = 7; ID_RS1 = 7; ID_USES_RS1 = 0; ID_USES_RS2 = 0; ID_RS2 = 7;
        #1 chk("lu_unused_src", ctrl(), C_NONE);
        ID_USES_RS1 = 1;
        #1 chk("lu_rs1", ctrl(), C_LU);
        EX_MEMREAD = 0;
        #1 chk("lu_not_load", ctrl(), C_NONE);
        tick();
        chk("lu_x0_cnt", STALL_COUNT, 1);

        // branch beats load-use
        clear_inputs();
        EX_MEMREAD = 1; EX_RD = 5; ID_RS2 = 5; ID_USES_RS2 = 1; EX_BRANCH_TAKEN = 1;
        #1 chk("br_vs_lu_ctrl", ctrl(), C_BR);
        tick();
        chk("br_vs_lu_cnt", STALL_COUNT, 1);
        chk("br_vs_lu_state", STATE, 1);
        clear_inputs();

        // branch under DMEM stall
        do_reset("r1");
        chk("r1_cnt", STALL_COUNT, 0);
        DMEM_BUSYWAIT = 1; EX_BRANCH_TAKEN = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("dm_ctrl%0d", i), ctrl(), C_BUSY);
            tick();
            chk($sformatf("dm_state%0d", i), STATE, 2);
        end
        DMEM_BUSYWAIT = 0;
        #1 chk("dm_redirect", ctrl(), C_BR);
        chk("dm_cnt", STALL_COUNT, 3);
        tick();
        chk("dm_back_run", STATE, 1);
        chk("dm_cnt_after", STALL_COUNT, 3);
        EX_BRANCH_TAKEN = 0;

        // busywait drop then re-assert
        DMEM_BUSYWAIT = 1; tick(); chk("gap_s1", STATE, 2);
        DMEM_BUSYWAIT = 0; tick(); chk("gap_s2", STATE, 1);
        DMEM_BUSYWAIT = 1; tick(); chk("gap_s3", STATE, 2);
        chk("gap_cnt", STALL_COUNT, 5);
        DMEM_BUSYWAIT = 0; tick();

        // watchdog
        do_reset("r2");
        IMEM_BUSYWAIT = 1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("wd_to_edge%0d", k), STALL_TIMEOUT, (k >= 4) ? 1 : 0);
        end
        chk("wd_cnt", STALL_COUNT, 6);
        IMEM_BUSYWAIT = 0;
        tick();
        chk("wd_sticky", STALL_TIMEOUT, 1);
        chk("wd_run", STATE, 1);
        tick();
        chk("wd_sticky2", STALL_TIMEOUT, 1);

        // async reset mid-stall, then busy during INIT delays RUN
        IMEM_BUSYWAIT = 1;
        tick();
        chk("mid_state", STATE, 2);
        @(negedge CLK);
        RESET = 1;
        #1;
        chk("mid_rst_state", STATE, 0);
        chk("mid_rst_ctrl", ctrl(), C_INIT);
        chk("mid_rst_to", STALL_TIMEOUT, 0);
        chk("mid_rst_cnt", STALL_COUNT, 0);
        RESET = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("init_busy%0d", k), STATE, 0);
        end
        chk("init_busy_ctrl", ctrl(), C_INIT);
        chk("init_busy_cnt", STALL_COUNT, 0);
        IMEM_BUSYWAIT = 0;
        tick();
        chk("init_busy_exit", STATE, 1);

        // saturation of 3-bit counter (watchdog also trips here)
        IMEM_BUSYWAIT = 1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 7 || k == 10)
                chk($sformatf("sat_cnt%0d", k), STALL_COUNT, 7);
        end
        IMEM_BUSYWAIT = 0;
        tick();
        chk("sat_hold", STALL_COUNT, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
